vga_scan_timer: RTL and testbench



---
 rtl/vga_scan_timer.sv | 96 +++++++++
 tb/tb_vga_scan_timer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/vga_scan_timer.sv
// Pixel-timing generator for the VGA path: splits CLOCK_50 into a half-rate pixel
// clock, scans the raster and drives the DAC and sync pins with matched delay.
module vga_scan_timer #(
    parameter int unsigned H_VIS  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_VIS  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [9:0] vga_r,
    input  logic [9:0] vga_g,
    input  logic [9:0] vga_b,
    output logic [9:0] x_addr,
    output logic [9:0] y_addr,
    output logic [9:0] vga_r_DAC,
    output logic [9:0] vga_g_DAC,
    output logic [9:0] vga_b_DAC,
    output logic       vga_clock,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank,
    output logic       vga_sync_dac,
    output logic       vblank,
    output logic       frame_tick
);

    localparam int unsigned CW       = 10;
    localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_VIS + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VIS + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic          pix_phase;
    logic [CW-1:0] x_next_c;
    logic [CW-1:0] y_next_c;
    logic          active_c;
    logic          hs_pulse_c;
    logic          vs_pulse_c;

    assign vga_clock    = pix_phase;
    assign vga_sync_dac = 1'b0;

    // Next raster position and the pixel attributes of the current position
    always_comb begin
        x_next_c = x_addr + CW'(1);
        y_next_c = y_addr;
        if (x_addr == CW'(H_TOTAL - 1)) begin
            x_next_c = '0;
            y_next_c = (y_addr == CW'(V_TOTAL - 1)) ? '0 : y_addr + CW'(1);
        end
        active_c   = (x_addr < CW'(H_VIS)) && (y_addr < CW'(V_VIS));
        hs_pulse_c = (x_addr >= CW'(HS_START)) && (x_addr < CW'(HS_END));
        vs_pulse_c = (y_addr >= CW'(VS_START)) && (y_addr < CW'(VS_END));
    end

    // Everything advances together when pix_phase is high, keeping DAC, syncs and
    // blank aligned one pixel behind the coordinates.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pix_phase  <= 1'b0;
            x_addr     <= '0;
            y_addr     <= '0;
            vga_r_DAC  <= '0;
            vga_g_DAC  <= '0;
            vga_b_DAC  <= '0;
            vga_hs     <= 1'b1;
            vga_vs     <= 1'b1;
            vga_blank  <= 1'b0;
            vblank     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            pix_phase  <= ~pix_phase;
            frame_tick <= 1'b0;
            if (pix_phase) begin
                x_addr     <= x_next_c;
                y_addr     <= y_next_c;
                vga_r_DAC  <= active_c ? vga_r : '0;
                vga_g_DAC  <= active_c ? vga_g : '0;
                vga_b_DAC  <= active_c ? vga_b : '0;
                vga_hs     <= ~hs_pulse_c;
                vga_vs     <= ~vs_pulse_c;
                vga_blank  <= active_c;
                vblank     <= (y_next_c >= CW'(V_VIS));
                frame_tick <= (x_next_c == '0) && (y_next_c == '0);
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_timer.sv
// Randomized bench for vga_scan_timer on a shrunk raster; expected outputs come
// from the number of clock edges since reset, using plain raster arithmetic.
module tb_vga_scan_timer;

    localparam int H_VIS = 16, H_FP = 4, H_SYNC = 6, H_BP = 4;
    localparam int V_VIS = 8,  V_FP = 2, V_SYNC = 2, V_BP = 3;
    localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME_PIX = HT * VT;

    logic       CLOCK_50;
    logic       reset;
    logic [9:0] vga_r, vga_g, vga_b;
    logic [9:0] x_addr, y_addr;
    logic [9:0] vga_r_DAC, vga_g_DAC, vga_b_DAC;
    logic       vga_clock, vga_hs, vga_vs, vga_blank, vga_sync_dac, vblank, frame_tick;

    int checks = 0;
    int errors = 0;
    int n = 0;
    int ticks_total = 0;
    logic [9:0] salt_r, salt_g, salt_b;

    vga_scan_timer #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .x_addr      (x_addr),
        .y_addr      (y_addr),
        .vga_r_DAC   (vga_r_DAC),
        .vga_g_DAC   (vga_g_DAC),
        .vga_b_DAC   (vga_b_DAC),
        .vga_clock   (vga_clock),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank   (vga_blank),
        .vga_sync_dac(vga_sync_dac),
        .vblank      (vblank),
        .frame_tick  (frame_tick)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d since reset)", tag, got, exp, n);
        end
    endtask

    // Colour the tile-map stage would return for a given coordinate
    function automatic logic [9:0] col_r(input int x, input int y);
        return 10'((x ^ (y << 5)) ^ int'(salt_r));
    endfunction
    function automatic logic [9:0] col_g(input int x, input int y);
        return 10'(y * 37 + x + int'(salt_g));
    endfunction
    function automatic logic [9:0] col_b(input int x, input int y);
        return 10'(x * y + int'(salt_b));
    endfunction

    // Compare every output against the raster position implied by n edges since reset
    task automatic check_all();
        int adv, px, py, cx, cy;
        logic act;
        adv = n / 2;
        cx  = adv % HT;
        cy  = (adv / HT) % VT;
        check("x_addr", 32'(x_addr), 32'(cx));
        check("y_addr", 32'(y_addr), 32'(cy));
        check("vga_clock", 32'(vga_clock), 32'(n % 2));
        check("vga_sync_dac", 32'(vga_sync_dac), 32'(0));
        check("vblank", 32'(vblank), 32'(cy >= V_VIS));
        check("frame_tick", 32'(frame_tick),
              32'((n % 2 == 0) && (adv > 0) && (adv % FRAME_PIX == 0)));
        if (adv == 0) begin
            check("dac_r", 32'(vga_r_DAC), 32'(0));
            check("dac_g", 32'(vga_g_DAC), 32'(0));
            check("dac_b", 32'(vga_b_DAC), 32'(0));
            check("vga_hs", 32'(vga_hs), 32'(1));
            check("vga_vs", 32'(vga_vs), 32'(1));
            check("vga_blank", 32'(vga_blank), 32'(0));
        end else begin
            px  = (adv - 1) % HT;
            py  = ((adv - 1) / HT) % VT;
            act = (px < H_VIS) && (py < V_VIS);
            check("dac_r", 32'(vga_r_DAC), act ? 32'(col_r(px, py)) : 32'(0));
            check("dac_g", 32'(vga_g_DAC), act ? 32'(col_g(px, py)) : 32'(0));
            check("dac_b", 32'(vga_b_DAC), act ? 32'(col_b(px, py)) : 32'(0));
            check("vga_hs", 32'(vga_hs),
                  32'(!((px >= H_VIS + H_FP) && (px < H_VIS + H_FP + H_SYNC))));
            check("vga_vs", 32'(vga_vs),
                  32'(!((py >= V_VIS + V_FP) && (py < V_VIS + V_FP + V_SYNC))));
            check("vga_blank", 32'(vga_blank), 32'(act));
        end
    endtask

    // One CLOCK_50 cycle: set reset, take the edge, check, then answer the new address
    task automatic tick(input logic rst);
        @(negedge CLOCK_50);
        reset = rst;
        @(posedge CLOCK_50);
        #1;
        ticks_total++;
        if (rst) n = 0;
        else n++;
        check_all();
        if (x_addr < 10'(H_VIS) && y_addr < 10'(V_VIS)) begin
            vga_r = col_r(int'(x_addr), int'(y_addr));
            vga_g = col_g(int'(x_addr), int'(y_addr));
            vga_b = col_b(int'(x_addr), int'(y_addr));
        end else begin
            vga_r = 10'($urandom);
            vga_g = 10'($urandom);
            vga_b = 10'($urandom);
        end
    endtask

    initial begin
        reset  = 1'b1;
        salt_r = 10'($urandom);
        salt_g = 10'($urandom);
        salt_b = 10'($urandom);
        vga_r  = 10'($urandom);
        vga_g  = 10'($urandom);
        vga_b  = 10'($urandom);

        repeat (3) tick(1'b1);
        repeat (2 * 2 * FRAME_PIX + 20) tick(1'b0);

        // Random mid-frame resets, each followed by a random run length
        for (int k = 0; k < 6; k++) begin
            int run_len, rst_len;
            run_len = int'($urandom_range(1, 2 * FRAME_PIX + 40));
            rst_len = int'($urandom_range(1, 3));
            repeat (rst_len) tick(1'b1);
            salt_r = 10'($urandom);
            repeat (run_len) tick(1'b0);
        end

        repeat (2) tick(1'b1);
        repeat (2 * 2 * FRAME_PIX + 10) tick(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: got %0d ticks expected completion", ticks_total);
        $fatal(1, "bench timed out");
    end

endmodule
